uart_tx_port: RTL and testbench

//  Memory-mapped UART transmitter on the core data bus, beside the panel. It streams the encoded

---
 rtl/uart_tx_port.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_tx_port.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
// uart_tx_port
//   Memory-mapped UART transmitter. The core writes bytes to TXDATA. Each byte goes into a
//   small TX FIFO and is sent as an 8N1 frame, LSB first. Firmware polls STATUS for FIFO
//   space and for dropped writes.
//
//   Register map (decode on address[WIDTH-1:2]):
//     BASE_ADDR     TXDATA  W: push wdata[7:0]          R: 0
//     BASE_ADDR+4   STATUS  W: wdata[3]=1 clears ovf    R: {count[7:0], overflow, full, empty, busy}
//
//   Ports
//     clk      core clock
//     nrst     asynchronous active-low reset
//     address  byte address from the core
//     wdata    write data from the core
//     enw      write strobe, sampled on posedge clk
//     hit      comb: address selects TXDATA or STATUS
//     rdata    comb read data, valid when hit
//     txd      serial line, idle high, driven from a flop
//     busy     frame in progress or FIFO not empty
//
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | start bit (low) for DIV clocks
//   DATA  | 8 data bits, LSB first, DIV clocks each
//   STOP  | stop bit (high) for DIV clocks; may chain straight into the next START
module uart_tx_port #(
    parameter int              WIDTH      = 32,
    parameter int              CLK_RATE   = 25_000_000,
    parameter int              BAUD       = 115_200,
    parameter int              FIFO_DEPTH = 16,
    parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0006_1A80
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] wdata,
    input  logic             enw,
    output logic             hit,
    output logic [WIDTH-1:0] rdata,
    output logic             txd,
    output logic             busy
);

    localparam int DIV = (CLK_RATE + BAUD / 2) / BAUD;
    localparam int BCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    localparam logic [WIDTH-1:0] STATUS_ADDR = BASE_ADDR + WIDTH'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------- decode
    logic sel_tx;
    logic sel_st;

    assign sel_tx = (address[WIDTH-1:2] == BASE_ADDR[WIDTH-1:2]);
    assign sel_st = (address[WIDTH-1:2] == STATUS_ADDR[WIDTH-1:2]);
    assign hit    = sel_tx | sel_st;

    // Only wdata[7:0] and wdata[3] are consumed; byte lane bits of the address are don't-care.
    logic unused_bits;
    assign unused_bits = ^{address[1:0], wdata[WIDTH-1:8]};

    // ---------------------------------------------------------------- FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          overflow;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_req = enw & sel_tx;
    // A pop on the same edge frees the head slot, so a push at full is still accepted.
    assign push     = push_req & (~full | pop);

    // Contents need no reset: count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req & full & ~pop) begin
                overflow <= 1'b1;
            end else if (enw & sel_st & wdata[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- serialiser
    state_t         state,    state_nx;
    logic [BCW-1:0] baud_cnt, baud_cnt_nx;
    logic [2:0]     bit_idx,  bit_idx_nx;
    logic [7:0]     shreg,    shreg_nx;
    logic           txd_q,    txd_nx;
    logic           bit_end;

    assign bit_end = (baud_cnt == '0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd_q    <= 1'b1;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_cnt_nx;
            bit_idx  <= bit_idx_nx;
            shreg    <= shreg_nx;
            txd_q    <= txd_nx;
        end
    end

    // shreg shifts right as bits go out, so the next data bit is always shreg[0].
    always_comb begin
        state_nx    = state;
        baud_cnt_nx = baud_cnt;
        bit_idx_nx  = bit_idx;
        shreg_nx    = shreg;
        txd_nx      = txd_q;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                txd_nx = 1'b1;
                if (!empty) begin
                    pop         = 1'b1;
                    shreg_nx    = mem[rd_ptr];
                    state_nx    = START;
                    baud_cnt_nx = BCW'(DIV - 1);
                    txd_nx      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx    = DATA;
                    bit_idx_nx  = '0;
                    txd_nx      = shreg[0];
                    shreg_nx    = {1'b0, shreg[7:1]};
                    baud_cnt_nx = BCW'(DIV - 1);
                end else begin
                    baud_cnt_nx = baud_cnt - BCW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_nx = BCW'(DIV - 1);
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                        txd_nx   = 1'b1;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                        txd_nx     = shreg[0];
                        shreg_nx   = {1'b0, shreg[7:1]};
                    end
                end else begin
                    baud_cnt_nx = baud_cnt - BCW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain directly into the next start bit: no idle gap between frames.
                    if (!empty) begin
                        pop         = 1'b1;
                        shreg_nx    = mem[rd_ptr];
                        state_nx    = START;
                        baud_cnt_nx = BCW'(DIV - 1);
                        txd_nx      = 1'b0;
                    end else begin
                        state_nx = IDLE;
                        txd_nx   = 1'b1;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt - BCW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                txd_nx   = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    assign txd  = txd_q;
    assign busy = (state != IDLE) | ~empty;

    logic [7:0] count8;
    assign count8 = 8'(count);

    always_comb begin
        rdata = '0;
        if (sel_st) begin
            rdata = WIDTH'({count8, overflow, full, empty, busy});
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
module tb_uart_tx_port;

    localparam logic [31:0] BASE   = 32'h0006_1A80;
    localparam logic [31:0] STATUS = 32'h0006_1A84;
    // (25_000_000 + 57_600) / 115_200 = 217 clocks per bit
    localparam int DIV   = 217;
    localparam int FRAME = 10 * DIV;

    logic        clk;
    logic        nrst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        enw;
    logic        hit;
    logic [31:0] rdata;
    logic        txd;
    logic        busy;

    uart_tx_port dut (
        .clk     (clk),
        .nrst    (nrst),
        .address (address),
        .wdata   (wdata),
        .enw     (enw),
        .hit     (hit),
        .rdata   (rdata),
        .txd     (txd),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Serial receiver model: samples each bit at its middle.
    logic [7:0] rxq[$];

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (nrst && txd == 1'b0) begin
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (DIV) @(negedge clk);
                check("rx_stop_bit", {31'd0, txd}, 32'd1);
                rxq.push_back(b);
            end
        end
    end

    task automatic at_cyc(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address = a;
        wdata   = d;
        enw     = 1'b1;
        @(posedge clk);
        #1;
        enw     = 1'b0;
        address = '0;
        wdata   = '0;
    endtask

    task automatic rd_status(output logic [31:0] v);
        address = STATUS;
        #1;
        v = rdata;
        address = '0;
    endtask

    // Check every bit of a frame whose write edge was w.
    task automatic check_frame(input int w, input logic [7:0] b);
        logic e;
        at_cyc(w);
        check("latency_txd_high", {31'd0, txd}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            at_cyc(w + 1 + DIV * k + DIV / 2);
            check($sformatf("frame_%02h_bit%0d", b, k), {31'd0, txd}, {31'd0, e});
        end
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp[$]);
        check({name, "_count"}, rxq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rxq.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), {24'd0, rxq[i]}, {24'd0, exp[i]});
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        do_wr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int w;
        logic [31:0] st;
        logic [7:0] exp_bytes[$];

        vecs[0] = '{STATUS,          1'b0, 32'h0,         1'b1, 32'h2};
        vecs[1] = '{BASE + 32'd6,    1'b0, 32'h0,         1'b1, 32'h2};
        vecs[2] = '{BASE,            1'b0, 32'h0,         1'b1, 32'h0};
        vecs[3] = '{BASE + 32'd3,    1'b0, 32'h0,         1'b1, 32'h0};
        vecs[4] = '{BASE + 32'd8,    1'b0, 32'h0,         1'b0, 32'h0};
        vecs[5] = '{BASE - 32'd4,    1'b0, 32'h0,         1'b0, 32'h0};
        vecs[6] = '{32'h0,           1'b0, 32'h0,         1'b0, 32'h0};
        vecs[7] = '{STATUS,          1'b1, 32'hFFFF_FFF7, 1'b1, 32'h2};
        vecs[8] = '{32'h1006_1A84,   1'b0, 32'h0,         1'b0, 32'h0};

        nrst    = 1'b0;
        address = '0;
        wdata   = '0;
        enw     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rd_status(st);
        check("reset_status", st, 32'h2);
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_txd", {31'd0, txd}, 32'd1);

        // Register decode table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
            address = vecs[i].addr;
            #1;
            check($sformatf("vec%0d_hit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
            if (vecs[i].exp_hit) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            address = '0;
            @(negedge clk);
        end
        check("idle_txd_after_table", {31'd0, txd}, 32'd1);

        // Single frame 0x55
        rxq.delete();
        wr(BASE, 32'h55);
        w = cyc;
        check_frame(w, 8'h55);
        at_cyc(w + FRAME);
        check("t1_busy_last", {31'd0, busy}, 32'd1);
        at_cyc(w + FRAME + 1);
        check("t1_busy_drop", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        exp_bytes = '{8'h55};
        check_rx("t1_rx", exp_bytes);

        // Back-to-back frames 0x41, 0xA5
        rxq.delete();
        wr(BASE, 32'h41);
        w = cyc;
        wr(BASE, 32'hA5);
        at_cyc(w + FRAME);
        check("t2_stop1", {31'd0, txd}, 32'd1);
        at_cyc(w + FRAME + 1);
        check("t2_start2_no_gap", {31'd0, txd}, 32'd0);
        at_cyc(w + 2 * FRAME);
        check("t2_busy_last", {31'd0, busy}, 32'd1);
        at_cyc(w + 2 * FRAME + 1);
        check("t2_busy_drop", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        exp_bytes = '{8'h41, 8'hA5};
        check_rx("t2_rx", exp_bytes);

        // Overflow: 18 consecutive writes, then push coinciding with pop at full
        rxq.delete();
        wr(BASE, 32'h00);
        w = cyc;
        for (int i = 1; i < 18; i++) wr(BASE, i);
        rd_status(st);
        check("t3_status_ovf", st, 32'h10D);
        wr(STATUS, 32'h8);
        rd_status(st);
        check("t3_status_cleared", st, 32'h105);
        at_cyc(w + FRAME);
        rd_status(st);
        check("t4_status_before", st, 32'h105);
        wr(BASE, 32'h77);
        rd_status(st);
        check("t4_status_after", st, 32'h105);
        at_cyc(w + 18 * FRAME + 1);
        check("t4_busy_drained", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        exp_bytes.delete();
        for (int i = 0; i < 17; i++) exp_bytes.push_back(8'(i));
        exp_bytes.push_back(8'h77);
        check_rx("t34_rx", exp_bytes);

        // Reset in the middle of data bit 3 of 0xFF
        wr(BASE, 32'hFF);
        w = cyc;
        at_cyc(w + 1 + 4 * DIV + DIV / 2);
        check("t5_busy_midframe", {31'd0, busy}, 32'd1);
        nrst = 1'b0;
        #1;
        check("t5_txd_reset", {31'd0, txd}, 32'd1);
        check("t5_busy_reset", {31'd0, busy}, 32'd0);
        rd_status(st);
        check("t5_status_reset", st, 32'h2);
        @(negedge clk);
        nrst = 1'b1;
        repeat (FRAME) @(negedge clk);
        check("t5_idle_txd", {31'd0, txd}, 32'd1);
        rxq.delete();
        wr(BASE, 32'h01);
        w = cyc;
        check_frame(w, 8'h01);
        at_cyc(w + FRAME + 1);
        check("t5_busy_drop", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        exp_bytes = '{8'h01};
        check_rx("t5_rx", exp_bytes);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
